// File: rtl/alu_serial_ctrl.sv
// Bit-serial ADD/SUB/XOR/SLT sequencer over one 1-bit slice, LSB first, carry held in a flop.
// Latency: legal op -> out_valid WIDTH+1 edges after acceptance; illegal op -> next edge.
// Backpressure: in_ready only in IDLE (no queueing); the result is held in DONE until out_ready.
module alu_serial_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero,
    output logic             out_err,
    output logic             busy
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_SLT = 3'b011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             cmsb;

    logic             accept;
    logic             op_legal;
    logic             last_bit;

    logic             bit_a;
    logic             bit_bin;
    logic             bit_sum;
    logic             bit_carry;
    logic             bit_res;

    logic             fin_cout;
    logic             fin_ovf;
    logic [WIDTH-1:0] fin_result;

    assign in_ready  = rst_n && (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == RUN) || (state == FIN);

    assign accept    = in_valid && in_ready;
    // Codes 000..011 are the only defined operations.
    assign op_legal  = (in_op[2] == 1'b0);
    assign last_bit  = (cnt == CW'(WIDTH - 1));

    // One bit slice: operand B optionally inverted, full adder, xor path.
    always_comb begin
        bit_a     = a_q[0];
        bit_bin   = b_q[0] ^ op_q[0];
        bit_sum   = bit_a ^ bit_bin ^ carry;
        bit_carry = (bit_a & bit_bin) | (bit_a & carry) | (bit_bin & carry);
        bit_res   = (op_q == OP_XOR) ? (a_q[0] ^ b_q[0]) : bit_sum;
    end

    // Final flags and SLT result from the carry chain; XOR reports no carry or overflow.
    always_comb begin
        fin_cout   = 1'b0;
        fin_ovf    = 1'b0;
        fin_result = out_result;
        if (op_q != OP_XOR) begin
            fin_cout = carry;
            fin_ovf  = cmsb ^ carry;
        end
        if (op_q == OP_SLT) begin
            fin_result = {{(WIDTH-1){1'b0}}, out_result[WIDTH-1] ^ fin_ovf};
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state sequencing: illegal ops skip the datapath entirely.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = op_legal ? RUN : DONE;
                end
            end
            RUN: begin
                if (last_bit) begin
                    state_nxt = FIN;
                end
            end
            FIN:  state_nxt = DONE;
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: latch operands, shift one bit per RUN cycle, finalise flags in FIN.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            cnt        <= '0;
            carry      <= 1'b0;
            cmsb       <= 1'b0;
            out_result <= '0;
            out_cout   <= 1'b0;
            out_ovf    <= 1'b0;
            out_zero   <= 1'b0;
            out_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q  <= in_op;
                        a_q   <= in_a;
                        b_q   <= in_b;
                        cnt   <= '0;
                        carry <= in_op[0];
                        if (!op_legal) begin
                            out_result <= '0;
                            out_cout   <= 1'b0;
                            out_ovf    <= 1'b0;
                            out_zero   <= 1'b1;
                            out_err    <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    a_q        <= a_q >> 1;
                    b_q        <= b_q >> 1;
                    carry      <= bit_carry;
                    out_result <= {bit_res, out_result[WIDTH-1:1]};
                    if (last_bit) begin
                        cmsb <= carry;
                        cnt  <= '0;
                    end else begin
                        cnt  <= cnt + CW'(1);
                    end
                end
                FIN: begin
                    out_result <= fin_result;
                    out_cout   <= fin_cout;
                    out_ovf    <= fin_ovf;
                    out_zero   <= (fin_result == '0);
                    out_err    <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
